// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and sizes for the two-requester multiplier-sharing arbiter.
package mult_arb_pkg;

    localparam int OP_W               = 8;
    localparam int PROD_W             = 16;
    localparam int TIMEOUT_CYCLES_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester and engine bundle of the arbiter; timeout_err exists only with MULT_ARB_TIMEOUT_EN.
// Handshake: a requester holds req until its ack pulse; a result is valid only in the rsp_valid cycle.
interface mult_share_arbiter_if;
    import mult_arb_pkg::*;

    logic [1:0]        req;
    logic [OP_W-1:0]   dataa_0;
    logic [OP_W-1:0]   datab_0;
    logic [OP_W-1:0]   dataa_1;
    logic [OP_W-1:0]   datab_1;
    logic [1:0]        ack;
    logic              eng_start;
    logic [OP_W-1:0]   eng_dataa;
    logic [OP_W-1:0]   eng_datab;
    logic              eng_done;
    logic [PROD_W-1:0] eng_product;
    logic [1:0]        rsp_valid;
    logic [PROD_W-1:0] rsp_product;
    logic              busy;
`ifdef MULT_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    modport slave (
        input  req, dataa_0, datab_0, dataa_1, datab_1, eng_done, eng_product,
        output ack, eng_start, eng_dataa, eng_datab, rsp_valid, rsp_product, busy
`ifdef MULT_ARB_TIMEOUT_EN
        , output timeout_err
`endif
    );

    modport master (
        output req, dataa_0, datab_0, dataa_1, datab_1, eng_done, eng_product,
        input  ack, eng_start, eng_dataa, eng_datab, rsp_valid, rsp_product, busy
`ifdef MULT_ARB_TIMEOUT_EN
        , input timeout_err
`endif
    );

endinterface

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin winner selection for two requesters; the pointer remembers the last served one.
module mult_arb_rr (
    input  logic       clk,
    input  logic       reset_a,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       win_idx,
    output logic       winner
);

    logic last_q;

    // Reset to "requester 1 served last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a)
            last_q <= 1'b1;
        else if (update)
            last_q <= win_idx;
    end

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential 8x8 multiplier between two requesters (IDLE/START/BUSY/RESP).
// Optional BUSY watchdog and sticky timeout_err are built with MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset_a,
    mult_share_arbiter_if.slave  bus,
    output state_t               state_dbg
);

    state_t            state_q, state_d;
    logic              win_q;
    logic              rr_winner;
    logic              grant;
    logic              done_take;
    logic              timeout_hit;
    logic [OP_W-1:0]   op_a_q, op_b_q;
    logic [PROD_W-1:0] prod_q;

    assign grant     = (state_q == IDLE) && (bus.req != 2'b00);
    assign done_take = (state_q == BUSY) && bus.eng_done;

    mult_arb_rr u_rr (
        .clk     (clk),
        .reset_a (reset_a),
        .req     (bus.req),
        .update  (state_q == RESP),
        .win_idx (win_q),
        .winner  (rr_winner)
    );

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = START;
            START:   state_d = BUSY;
            BUSY:    if (done_take || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured only on a grant, so they stay frozen until the next IDLE grant.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            win_q  <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
            prod_q <= '0;
        end else begin
            if (grant) begin
                win_q  <= rr_winner;
                op_a_q <= rr_winner ? bus.dataa_1 : bus.dataa_0;
                op_b_q <= rr_winner ? bus.datab_1 : bus.datab_0;
            end
            if (done_take)
                prod_q <= bus.eng_product;
            else if (timeout_hit)
                prod_q <= '0;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             timeout_err_q;

    // Counter value is the index of the current BUSY cycle; a late done still wins the tie.
    assign timeout_hit = (state_q == BUSY) && !bus.eng_done &&
                         (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == BUSY)
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            else
                to_cnt_q <= '0;
            if (timeout_hit)
                timeout_err_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign bus.ack         = (state_q == START) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid   = (state_q == RESP)  ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.eng_start   = (state_q == START);
    assign bus.busy        = (state_q != IDLE);
    assign bus.eng_dataa   = op_a_q;
    assign bus.eng_datab   = op_b_q;
    assign bus.rsp_product = prod_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: vector table plus hand-written corner sequences.
module tb_mult_share_arbiter;
    import mult_arb_pkg::*;

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  a0, b0, a1, b1;
        logic        win;
        logic [15:0] prod;
        int          lat;
        bit          done_hold;
    } vec_t;

    logic   clk = 1'b0;
    logic   reset_a = 1'b0;
    state_t state_dbg;
    int     n_checks = 0;
    int     n_fail = 0;
    vec_t   vecs[7];
    bit     got;
`ifdef MULT_ARB_TIMEOUT_EN
    bit     seen;
    int     n_to;
`endif

    mult_share_arbiter_if bus();

    mult_share_arbiter #(.TIMEOUT_CYCLES(15)) dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_a = 1'b0;
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ack != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check("ack_seen", 32'(ok), 32'd1);
    endtask

    // One full transaction; the engine answers lat cycles after entering BUSY.
    task automatic do_txn(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic w,
                          input logic [15:0] p, input int lat, input bit hold, input bit done_hold);
        logic [1:0] exp_oh;
        logic [7:0] ea, eb;
        bit         ok;
        exp_oh = w ? 2'b10 : 2'b01;
        ea = w ? a1 : a0;
        eb = w ? b1 : b0;
        bus.req = r;
        bus.dataa_0 = a0;
        bus.datab_0 = b0;
        bus.dataa_1 = a1;
        bus.datab_1 = b1;
        wait_ack(ok);
        if (!ok) begin
            bus.req = 2'b00;
            return;
        end
        check("ack", 32'(bus.ack), 32'(exp_oh));
        check("eng_start", 32'(bus.eng_start), 32'd1);
        check("eng_dataa", 32'(bus.eng_dataa), 32'(ea));
        check("eng_datab", 32'(bus.eng_datab), 32'(eb));
        if (!hold) bus.req[w] = 1'b0;
        @(negedge clk);
        check("start_one_cycle", 32'({bus.eng_start, bus.ack}), 32'd0);
        check("busy", 32'(bus.busy), 32'd1);
        repeat (lat) begin
            @(negedge clk);
            check("busy_quiet", 32'({bus.rsp_valid, bus.ack}), 32'd0);
        end
        bus.eng_done = 1'b1;
        bus.eng_product = {8'h00, ea} * {8'h00, eb};
        @(negedge clk);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_oh));
        check("rsp_product", 32'(bus.rsp_product), 32'(p));
        check("held_dataa", 32'(bus.eng_dataa), 32'(ea));
        check("resp_no_ack", 32'(bus.ack), 32'd0);
        if (!done_hold) bus.eng_done = 1'b0;
        @(negedge clk);
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        check("back_idle", 32'(state_dbg), 32'(IDLE));
        bus.eng_done = 1'b0;
        if (done_hold) begin
            @(negedge clk);
            check("done_in_resp_ignored", 32'({bus.rsp_valid, bus.busy}), 32'd0);
            check("product_kept", 32'(bus.rsp_product), 32'(p));
        end
    endtask

    initial begin
        vecs[0] = '{2'b11, 8'hFF, 8'hFF, 8'd3,  8'd5,  1'b0, 16'hFE01, 2, 1'b0};
        vecs[1] = '{2'b10, 8'hFF, 8'hFF, 8'd3,  8'd5,  1'b1, 16'd15,   0, 1'b0};
        vecs[2] = '{2'b01, 8'd12, 8'd13, 8'd0,  8'd0,  1'b0, 16'd156,  3, 1'b1};
        vecs[3] = '{2'b11, 8'd2,  8'd3,  8'd10, 8'd10, 1'b1, 16'd100,  1, 1'b0};
        vecs[4] = '{2'b11, 8'd2,  8'd3,  8'd10, 8'd10, 1'b0, 16'd6,    5, 1'b0};
        vecs[5] = '{2'b10, 8'd2,  8'd3,  8'd7,  8'd9,  1'b1, 16'd63,   0, 1'b0};
        vecs[6] = '{2'b11, 8'd0,  8'd200, 8'd255, 8'd1, 1'b0, 16'd0,   4, 1'b0};

        bus.req = 2'b00;
        bus.dataa_0 = '0;
        bus.datab_0 = '0;
        bus.dataa_1 = '0;
        bus.datab_1 = '0;
        bus.eng_done = 1'b0;
        bus.eng_product = '0;
        repeat (2) @(negedge clk);

        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_eng_start", 32'(bus.eng_start), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rsp_product", 32'(bus.rsp_product), 32'd0);
        check("rst_operands", 32'({bus.eng_dataa, bus.eng_datab}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
`ifdef MULT_ARB_TIMEOUT_EN
        check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
`endif
        reset_a = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            do_txn(vecs[i].req, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                   vecs[i].win, vecs[i].prod, vecs[i].lat, 1'b0, vecs[i].done_hold);
        bus.req = 2'b00;

        // Both requesters held for four transactions: grants must alternate from 0.
        do_reset();
        for (int k = 0; k < 4; k++)
            do_txn(2'b11, 8'd4, 8'd5, 8'd6, 8'd7, (k % 2) == 1,
                   ((k % 2) == 1) ? 16'd42 : 16'd20, 1, 1'b1, 1'b0);
        bus.req = 2'b00;
        @(negedge clk);
        check("hold_release_idle", 32'(state_dbg), 32'(IDLE));

        // A request raised and dropped while busy must never be granted.
        bus.req = 2'b01;
        bus.dataa_0 = 8'd2;
        bus.datab_0 = 8'd2;
        wait_ack(got);
        bus.req = 2'b00;
        @(negedge clk);
        bus.req = 2'b10;
        @(negedge clk);
        bus.req = 2'b00;
        bus.eng_done = 1'b1;
        bus.eng_product = 16'd4;
        @(negedge clk);
        check("glitch_rsp", 32'(bus.rsp_valid), 32'b01);
        bus.eng_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("glitch_no_ack", 32'({bus.ack, bus.busy}), 32'd0);
        end

        // eng_done while idle changes nothing.
        bus.eng_done = 1'b1;
        bus.eng_product = 16'h1234;
        repeat (2) begin
            @(negedge clk);
            check("done_in_idle", 32'({bus.rsp_valid, bus.busy}), 32'd0);
        end
        check("done_in_idle_product", 32'(bus.rsp_product), 32'd4);
        bus.eng_done = 1'b0;

        // Reset in the middle of BUSY aborts silently.
        bus.req = 2'b01;
        bus.dataa_0 = 8'd9;
        bus.datab_0 = 8'd9;
        wait_ack(got);
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        check("mid_busy_state", 32'(state_dbg), 32'(BUSY));
        reset_a = 1'b0;
        #1;
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_outputs", 32'({bus.ack, bus.rsp_valid, bus.eng_start, bus.busy}), 32'd0);
        check("abort_data", 32'({bus.rsp_product, bus.eng_dataa, bus.eng_datab}), 32'd0);
        @(negedge clk);
        reset_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        do_txn(2'b10, 8'd0, 8'd0, 8'd7, 8'd9, 1'b1, 16'd63, 2, 1'b0, 1'b0);

`ifdef MULT_ARB_TIMEOUT_EN
        bus.req = 2'b01;
        bus.dataa_0 = 8'd5;
        bus.datab_0 = 8'd5;
        wait_ack(got);
        bus.req = 2'b00;
        seen = 1'b0;
        n_to = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) begin
                seen = 1'b1;
                n_to = i;
            end
        end
        check("timeout_latency", 32'(n_to), 32'd16);
        check("timeout_rsp_valid", 32'(bus.rsp_valid), 32'b01);
        check("timeout_product", 32'(bus.rsp_product), 32'd0);
        check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
        repeat (2) @(negedge clk);
        check("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
        do_reset();
        check("timeout_err_cleared", 32'(bus.timeout_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
